// File: rtl/shift_pkg.sv
`default_nettype none
// ============================================================================
// Module      : shift_pkg
// Description : Shared types and encodings for the parametrised shift register.
// Revision    : 1.0 - initial release
// ============================================================================
package shift_pkg;

    typedef enum logic [0:0] {
        IDLE  = 1'b0,
        SHIFT = 1'b1
    } state_t;

    localparam logic DIR_RIGHT    = 1'b0;
    localparam logic DIR_LEFT     = 1'b1;
    localparam logic MODE_LOGICAL = 1'b0;
    localparam logic MODE_ROTATE  = 1'b1;

endpackage : shift_pkg
`default_nettype wire

// File: rtl/shift_counter.sv
`default_nettype none
// ============================================================================
// Module      : shift_counter
// Description : Saturating burst counter with a terminal flag on the last step.
// Revision    : 1.0 - initial release
// ============================================================================
module shift_counter #(
    parameter int MAX = 8,
    parameter int CW  = $clog2(MAX + 1)
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          i_clr,
    input  logic          i_inc,
    output logic [CW-1:0] o_count,
    output logic          o_terminal
);

    logic [CW-1:0] r_count;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_count <= '0;
        end else if (i_clr) begin
            r_count <= '0;
        end else if (i_inc && (r_count != CW'(MAX))) begin
            r_count <= r_count + 1'b1;
        end
    end

    // Terminal marks the increment that brings the count to MAX.
    assign o_terminal = i_inc && (r_count == CW'(MAX - 1));
    assign o_count    = r_count;

endmodule : shift_counter
`default_nettype wire

// File: rtl/shift_register_param.sv
`default_nettype none
// ============================================================================
// Module      : shift_register_param
// Description : Shift register with parallel load, single-step shift and a
//               WIDTH-shift burst, in logical or rotate mode, left or right.
// Revision    : 1.0 - initial release
// ============================================================================
module shift_register_param
    import shift_pkg::*;
#(
    parameter int               WIDTH       = 8,
    parameter logic [WIDTH-1:0] RESET_VALUE = '0
) (
    input  logic                         clk,
    input  logic                         rst,
    input  logic [WIDTH-1:0]             A,
    input  logic                         load,
    input  logic                         enable,
    input  logic                         start,
    input  logic                         dir,
    input  logic                         mode,
    input  logic                         serial_in,
    output logic [WIDTH-1:0]             shift,
    output logic                         serial_out,
    output logic                         busy,
    output logic                         done,
    output logic [$clog2(WIDTH+1)-1:0]   count
);

    localparam int c_CW = $clog2(WIDTH + 1);

    state_t           r_state;
    state_t           w_state_next;
    logic [WIDTH-1:0] r_shift;
    logic [WIDTH-1:0] w_shifted;
    logic             w_fill;
    logic             r_done;
    logic             w_do_load;
    logic             w_do_shift;
    logic             w_clr;
    logic             w_inc;
    logic             w_terminal;
    logic [c_CW-1:0]  w_count;

    shift_counter #(
        .MAX (WIDTH),
        .CW  (c_CW)
    ) u_counter (
        .clk        (clk),
        .rst        (rst),
        .i_clr      (w_clr),
        .i_inc      (w_inc),
        .o_count    (w_count),
        .o_terminal (w_terminal)
    );

    assign serial_out = (dir == DIR_LEFT) ? r_shift[WIDTH-1] : r_shift[0];

    always_comb begin
        w_fill    = (mode == MODE_ROTATE) ? serial_out : serial_in;
        w_shifted = (dir == DIR_LEFT) ? {r_shift[WIDTH-2:0], w_fill}
                                      : {w_fill, r_shift[WIDTH-1:1]};
    end

    always_comb begin
        w_state_next = r_state;
        w_do_load    = 1'b0;
        w_do_shift   = 1'b0;
        w_clr        = 1'b0;
        w_inc        = 1'b0;
        case (r_state)
            IDLE: begin
                // load beats start beats enable; a dropped start is not queued
                if (load) begin
                    w_do_load = 1'b1;
                end else if (start) begin
                    w_clr        = 1'b1;
                    w_state_next = SHIFT;
                end else if (enable) begin
                    w_do_shift = 1'b1;
                end
            end
            SHIFT: begin
                w_do_shift = 1'b1;
                w_inc      = 1'b1;
                if (w_terminal) begin
                    w_state_next = IDLE;
                end
            end
            default: w_state_next = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state <= IDLE;
            r_shift <= RESET_VALUE;
            r_done  <= 1'b0;
        end else begin
            r_state <= w_state_next;
            r_done  <= w_terminal;
            if (w_do_load) begin
                r_shift <= A;
            end else if (w_do_shift) begin
                r_shift <= w_shifted;
            end
        end
    end

    assign shift = r_shift;
    assign busy  = (r_state == SHIFT);
    assign done  = r_done;
    assign count = w_count;

endmodule : shift_register_param
`default_nettype wire

// File: tb/tb_shift_register_param.sv
`default_nettype none
// ============================================================================
// Module      : tb_shift_register_param
// Description : Directed self-checking bench for 8-bit and 16-bit instances.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_shift_register_param;

    logic        clk;
    logic        rst;
    int          checks;
    int          failures;

    logic [7:0]  a8;
    logic        load8, en8, start8, dir8, mode8, sin8;
    logic [7:0]  shift8;
    logic        so8, busy8, done8;
    logic [3:0]  cnt8;

    logic [15:0] a16;
    logic        load16, en16, start16, dir16, mode16, sin16;
    logic [15:0] shift16;
    logic        so16, busy16, done16;
    logic [4:0]  cnt16;

    shift_register_param #(.WIDTH(8), .RESET_VALUE(8'h5A)) u_dut8 (
        .clk(clk), .rst(rst), .A(a8), .load(load8), .enable(en8), .start(start8),
        .dir(dir8), .mode(mode8), .serial_in(sin8), .shift(shift8),
        .serial_out(so8), .busy(busy8), .done(done8), .count(cnt8)
    );

    shift_register_param #(.WIDTH(16)) u_dut16 (
        .clk(clk), .rst(rst), .A(a16), .load(load16), .enable(en16), .start(start16),
        .dir(dir16), .mode(mode16), .serial_in(sin16), .shift(shift16),
        .serial_out(so16), .busy(busy16), .done(done16), .count(cnt16)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic load8_val(input logic [7:0] v);
        a8 = v; load8 = 1'b1;
        step();
        load8 = 1'b0;
    endtask

    task automatic test_reset();
        load8_val(8'h00);
        if (shift8 !== 8'h00) begin failures++; $display("FAIL pre_reset_load shift=%h exp=00", shift8); end
        checks++;
        #2 rst = 1'b1;
        #1;
        if (shift8 !== 8'h5A) begin failures++; $display("FAIL reset_shift got=%h exp=5a", shift8); end
        checks++;
        if ({busy8, done8, cnt8} !== 6'b0) begin failures++; $display("FAIL reset_flags busy=%b done=%b count=%0d exp=0", busy8, done8, cnt8); end
        checks++;
        step();
        rst = 1'b0;
        step();
        if (shift8 !== 8'h5A) begin failures++; $display("FAIL reset_hold got=%h exp=5a", shift8); end
        checks++;
    endtask

    task automatic test_load_step();
        load8_val(8'hCA);
        if (shift8 !== 8'hCA) begin failures++; $display("FAIL load got=%h exp=ca", shift8); end
        checks++;
        dir8 = 1'b0; mode8 = 1'b0; sin8 = 1'b1; en8 = 1'b1;
        step();
        en8 = 1'b0;
        if (shift8 !== 8'hE5) begin failures++; $display("FAIL step_right_logical got=%h exp=e5", shift8); end
        checks++;
        dir8 = 1'b1; mode8 = 1'b1; en8 = 1'b1;
        step();
        en8 = 1'b0;
        if (shift8 !== 8'hCB) begin failures++; $display("FAIL step_left_rotate got=%h exp=cb", shift8); end
        checks++;
        if (cnt8 !== 4'd0 || busy8 !== 1'b0) begin failures++; $display("FAIL step_no_count count=%0d busy=%b exp=0,0", cnt8, busy8); end
        checks++;
    endtask

    task automatic test_rotate_burst();
        logic [7:0] exp_seq [8] = '{8'h95, 8'h2B, 8'h56, 8'hAC, 8'h59, 8'hB2, 8'h65, 8'hCA};
        load8_val(8'hCA);
        dir8 = 1'b1; mode8 = 1'b1; start8 = 1'b1;
        step();
        start8 = 1'b0;
        if (busy8 !== 1'b1 || cnt8 !== 4'd0 || shift8 !== 8'hCA) begin
            failures++; $display("FAIL rot_start busy=%b count=%0d shift=%h exp=1,0,ca", busy8, cnt8, shift8);
        end
        checks++;
        for (int k = 1; k <= 8; k++) begin
            step();
            if (shift8 !== exp_seq[k-1] || cnt8 !== 4'(k) || busy8 !== (k < 8) || done8 !== (k == 8)) begin
                failures++;
                $display("FAIL rot_step%0d shift=%h count=%0d busy=%b done=%b exp=%h,%0d,%b,%b",
                         k, shift8, cnt8, busy8, done8, exp_seq[k-1], k, k < 8, k == 8);
            end
            checks++;
        end
        en8 = 1'b1;
        step();
        en8 = 1'b0;
        if (done8 !== 1'b0 || cnt8 !== 4'd8 || shift8 !== 8'h95) begin
            failures++; $display("FAIL rot_after done=%b count=%0d shift=%h exp=0,8,95", done8, cnt8, shift8);
        end
        checks++;
    endtask

    task automatic test_logical_burst();
        logic [7:0] exp_so = 8'b1100_1010;
        load8_val(8'hCA);
        dir8 = 1'b0; mode8 = 1'b0; sin8 = 1'b0; start8 = 1'b1;
        step();
        start8 = 1'b0;
        for (int k = 0; k < 8; k++) begin
            if (so8 !== exp_so[k]) begin failures++; $display("FAIL lr_serial_out%0d got=%b exp=%b", k, so8, exp_so[k]); end
            checks++;
            a8 = 8'hFF;
            load8  = (k == 1);
            en8    = (k == 3);
            start8 = (k == 4);
            step();
        end
        load8 = 1'b0; en8 = 1'b0; start8 = 1'b0;
        if (shift8 !== 8'h00 || done8 !== 1'b1 || cnt8 !== 4'd8) begin
            failures++; $display("FAIL lr_final shift=%h done=%b count=%0d exp=00,1,8", shift8, done8, cnt8);
        end
        checks++;
    endtask

    task automatic test_back_to_back();
        load8_val(8'h81);
        dir8 = 1'b1; mode8 = 1'b1; start8 = 1'b1;
        step();
        start8 = 1'b0;
        repeat (8) step();
        if (done8 !== 1'b1) begin failures++; $display("FAIL b2b_first_done got=%b exp=1", done8); end
        checks++;
        start8 = 1'b1;
        step();
        start8 = 1'b0;
        if (busy8 !== 1'b1 || cnt8 !== 4'd0 || done8 !== 1'b0) begin
            failures++; $display("FAIL b2b_restart busy=%b count=%0d done=%b exp=1,0,0", busy8, cnt8, done8);
        end
        checks++;
        repeat (8) step();
        if (done8 !== 1'b1 || shift8 !== 8'h81) begin
            failures++; $display("FAIL b2b_second done=%b shift=%h exp=1,81", done8, shift8);
        end
        checks++;
    endtask

    task automatic test_reset_midburst();
        logic seen_done;
        load8_val(8'h3C);
        dir8 = 1'b0; mode8 = 1'b1; start8 = 1'b1;
        step();
        start8 = 1'b0;
        repeat (4) step();
        if (cnt8 !== 4'd4 || shift8 !== 8'hC3) begin
            failures++; $display("FAIL mid_count count=%0d shift=%h exp=4,c3", cnt8, shift8);
        end
        checks++;
        #2 rst = 1'b1;
        #1;
        if (shift8 !== 8'h5A || busy8 !== 1'b0 || done8 !== 1'b0 || cnt8 !== 4'd0) begin
            failures++; $display("FAIL mid_reset shift=%h busy=%b done=%b count=%0d exp=5a,0,0,0", shift8, busy8, done8, cnt8);
        end
        checks++;
        step();
        rst = 1'b0;
        seen_done = 1'b0;
        for (int k = 0; k < 8; k++) begin
            step();
            seen_done = seen_done | done8 | busy8;
        end
        if (seen_done !== 1'b0 || shift8 !== 8'h5A) begin
            failures++; $display("FAIL mid_no_done activity=%b shift=%h exp=0,5a", seen_done, shift8);
        end
        checks++;
    endtask

    task automatic test_width16();
        a16 = 16'hBEEF; load16 = 1'b1;
        step();
        load16 = 1'b0;
        dir16 = 1'b1; mode16 = 1'b1; start16 = 1'b1;
        step();
        start16 = 1'b0;
        for (int k = 1; k <= 16; k++) begin
            step();
            if (cnt16 !== 5'(k) || busy16 !== (k < 16) || done16 !== (k == 16)) begin
                failures++;
                $display("FAIL w16_step%0d count=%0d busy=%b done=%b exp=%0d,%b,%b", k, cnt16, busy16, done16, k, k < 16, k == 16);
            end
            checks++;
        end
        if (shift16 !== 16'hBEEF) begin failures++; $display("FAIL w16_final shift=%h exp=beef", shift16); end
        checks++;
        step();
        if (done16 !== 1'b0 || cnt16 !== 5'd16) begin
            failures++; $display("FAIL w16_after done=%b count=%0d exp=0,16", done16, cnt16);
        end
        checks++;
    endtask

    initial begin
        checks = 0; failures = 0;
        rst = 1'b1;
        a8 = '0; load8 = 0; en8 = 0; start8 = 0; dir8 = 0; mode8 = 0; sin8 = 0;
        a16 = '0; load16 = 0; en16 = 0; start16 = 0; dir16 = 0; mode16 = 0; sin16 = 0;
        step();
        step();
        rst = 1'b0;
        step();
        test_reset();
        test_load_step();
        test_rotate_burst();
        test_logical_burst();
        test_back_to_back();
        test_reset_midburst();
        test_width16();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule : tb_shift_register_param
`default_nettype wire

// File: doc/shift_register_param.md
# shift_register_param

Parametrised shift register for the serial adder datapath and any later bit-serial unit. Supports parallel load, single-step shifting under `enable`, and an automatic burst of exactly `WIDTH` shifts started by `start`. Burst progress is reported through `busy`, `count` and a one-cycle `done` pulse. Direction (left/right) and mode (logical shift with serial fill, or rotate) are selectable, and the bit leaving the register is always visible on `serial_out`.

## Interface
- `WIDTH`, default 8: register width in bits, ≥ 2.
- `RESET_VALUE`, default 0: value of `shift` after reset, `WIDTH` bits.
- `clk`  in  1: sole clock; all state updates on the rising edge.
- `rst`  in  1: reset, asynchronous and active-high.
- `A`  in  `WIDTH`: parallel load data.
- `load`  in  1: parallel load request.
- `enable`  in  1: single-step shift request.
- `start`  in  1: burst request.
- `dir`  in  1: 0 = shift right (toward LSB), 1 = shift left.
- `mode`  in  1: 0 = logical (vacated bit takes `serial_in`), 1 = rotate.
- `serial_in`  in  1: fill bit in logical mode.
- `shift`  out  `WIDTH`: register contents.
- `serial_out`  out  1: next bit to leave; `shift[0]` when `dir`=0, `shift[WIDTH-1]` when `dir`=1; combinational from `shift` and `dir`.
- `busy`  out  1: high while in SHIFT.
- `done`  out  1: one-cycle pulse when a burst completes.
- `count`  out  `$clog2(WIDTH+1)`: shifts completed in the current or most recent burst.

## Operation
- **Reset values:** `shift`=`RESET_VALUE`, state=IDLE, `busy`=0, `done`=0, `count`=0.
- **States:** IDLE and SHIFT.
- **IDLE priority:** `load` > `start` > `enable`.
  - `load`: `shift`←`A`.
  - `start`: `count`←0, go to SHIFT; no shift on this edge.
  - `enable`: one shift per edge; `count` unchanged.
- **SHIFT:** one shift per edge and `count`←`count`+1. On the edge where `count` becomes `WIDTH`, return to IDLE and assert `done` for the following cycle.
- **During SHIFT:** `load`, `start` and `enable` are ignored; `dir`, `mode` and `serial_in` are sampled every edge.
- **Shift rules:**
  - Right: `shift`←{fill, `shift[WIDTH-1:1]`}.
  - Left: `shift`←{`shift[WIDTH-2:0]`, fill}.
  - fill = `serial_in` in logical mode; fill = the outgoing bit in rotate mode.
- **`count`** holds `WIDTH` after a burst until the next `start` or reset. `count` saturates, never wraps.
- **`done`:** cleared on the next edge unconditionally. A `start` in the `done` cycle is accepted, since the block is already in IDLE.

## Timing
- `start` sampled at edge N:
  - `busy`=1 from N until edge N+`WIDTH`.
  - Shifts occur at edges N+1 … N+`WIDTH`.
  - `done`=1 during the cycle after edge N+`WIDTH`.
- Burst length is `WIDTH` shifts; `start` to `done` is `WIDTH`+1 edges.
- `load` and single-step `enable` take effect at the sampling edge, with no extra latency.
- `serial_out` has zero latency from `shift`/`dir`; the value sampled before edge N+k is the bit shifted out at edge N+k.
- `rst` mid-burst: outputs return to reset values immediately (asynchronously), and no `done` is produced.
- Simultaneous `load` and `start` in IDLE: only the load happens; `start` is dropped, not queued.

## Structure
- **Package `shift_pkg`:**
  - State enum `{IDLE, SHIFT}`.
  - `DIR_RIGHT`=0, `DIR_LEFT`=1.
  - `MODE_LOGICAL`=0, `MODE_ROTATE`=1.
- **Sub-module `shift_counter`** (parameter `MAX`): clear, increment, saturate, and a terminal flag marking `count`=`MAX`-1 on an increment. It drives the SHIFT→IDLE transition.
- The shift datapath and FSM live in `shift_register_param`.

## Test plan
- **Reset:** with `RESET_VALUE`=8'h5A, assert `rst` asynchronously mid-cycle → `shift`=8'h5A, `busy`=0, `done`=0, `count`=0 before the next edge.
- **Load and single step:** `load`, `A`=8'hCA; then one `enable` with `dir`=0, `mode`=0, `serial_in`=1 → 8'hE5. Then `dir`=1, `mode`=1, one `enable` → 8'hCB.
- **Rotate burst:** load 8'hCA, `start` with `dir`=1, `mode`=1 → `busy` for 8 shifts, `count` 1…8, `done` for exactly one cycle, final `shift`=8'hCA.
- **Logical right burst:** load 8'hCA, `serial_in`=0 → `serial_out` sequence 0,1,0,1,0,0,1,1, final `shift`=8'h00. During the burst, `load`/`enable`/`start` pulses have no effect.
- **Boundary:** `start` asserted in the `done` cycle → new burst begins. `rst` at shift 4 of a burst → no `done`, outputs at reset values.
- **Width:** repeat the rotate burst with `WIDTH`=16, `A`=16'hBEEF → 16 shifts, `count`=16, `shift`=16'hBEEF.
